// File: rtl/stage_d_ex.sv
`default_nettype none
// =============================================================================
// Module      : stage_d_ex
// Description : Polaris decode stage (F -> D -> X) for the OP-IMM, OP and LUI
//               groups, with back-pressure hold and RAW hazard handling.
//               Optional feature macro: STAGE_D_FWD_EN (forward x_dat_i
//               instead of interlocking).
// Revision    : 1.0
// =============================================================================
module stage_d_ex #(
    parameter int          XLEN   = 64,
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            f_ack_i,
    input  logic [31:0]     f_dat_i,
    output logic            d_ready_o,
    input  logic            x_stall_i,
    input  logic            x_we_i,
    input  logic [4:0]      x_rd_i,
    input  logic [XLEN-1:0] x_dat_i,
    output logic [4:0]      w_rs1_o,
    output logic [4:0]      w_rs2_o,
    input  logic [XLEN-1:0] w_dat1_i,
    input  logic [XLEN-1:0] w_dat2_i,
    output logic            d_valid_o,
    output logic [XLEN-1:0] d_vs1_o,
    output logic [XLEN-1:0] d_vs2_o,
    output logic [4:0]      d_rd_o,
    output logic [3:0]      d_aluop_o,
    output logic            d_illegal_o
);

    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;

    logic [31:0]     r_ir;
    logic            r_valid;

    logic [6:0]      w_opc;
    logic [2:0]      w_fn3;
    logic [6:0]      w_fn7;
    logic [5:0]      w_shamt6;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_shamt_bad;

    logic [3:0]      w_dec_op;
    logic            w_dec_ill;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_sel_imm;
    logic            w_zero_a;
    logic [XLEN-1:0] w_dec_imm;

    logic            w_x_hit;
    logic            w_haz1;
    logic            w_haz2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_interlock;
    logic            w_hold;

    assign w_opc   = r_ir[6:0];
    assign w_fn3   = r_ir[14:12];
    assign w_fn7   = r_ir[31:25];
    assign w_rs1_o = r_ir[19:15];
    assign w_rs2_o = r_ir[24:20];

    assign w_imm_i  = XLEN'($signed(r_ir[31:20]));
    assign w_imm_u  = XLEN'($signed({r_ir[31:12], 12'h000}));
    // Bit 25 belongs to the shift amount only on a 64-bit datapath.
    assign w_shamt6 = (XLEN == 64) ? r_ir[25:20] : {1'b0, r_ir[24:20]};
    assign w_shamt  = XLEN'(w_shamt6);
    assign w_shamt_bad = (XLEN == 32) && r_ir[25];

    function automatic logic [3:0] f_base_op(input logic [2:0] fn3);
        case (fn3)
            3'b000:  f_base_op = c_ALU_ADD;
            3'b001:  f_base_op = c_ALU_SLL;
            3'b010:  f_base_op = c_ALU_SLT;
            3'b011:  f_base_op = c_ALU_SLTU;
            3'b100:  f_base_op = c_ALU_XOR;
            3'b101:  f_base_op = c_ALU_SRL;
            3'b110:  f_base_op = c_ALU_OR;
            default: f_base_op = c_ALU_AND;
        endcase
    endfunction

    always_comb begin
        w_dec_op  = c_ALU_ADD;
        w_dec_ill = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_sel_imm = 1'b0;
        w_zero_a  = 1'b0;
        w_dec_imm = '0;
        case (w_opc)
            c_OPC_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_sel_imm = 1'b1;
                w_dec_imm = w_imm_i;
                w_dec_op  = f_base_op(w_fn3);
                if (w_fn3 == 3'b001) begin
                    w_dec_imm = w_shamt;
                    w_dec_ill = (r_ir[31:26] != 6'b000000) || w_shamt_bad;
                end else if (w_fn3 == 3'b101) begin
                    w_dec_imm = w_shamt;
                    w_dec_op  = r_ir[30] ? c_ALU_SRA : c_ALU_SRL;
                    w_dec_ill = ((r_ir[31:26] != 6'b000000) && (r_ir[31:26] != 6'b010000))
                                || w_shamt_bad;
                end
            end
            c_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_fn7 == 7'b0000000) begin
                    w_dec_op = f_base_op(w_fn3);
                end else if (w_fn7 == 7'b0100000 && w_fn3 == 3'b000) begin
                    w_dec_op = c_ALU_SUB;
                end else if (w_fn7 == 7'b0100000 && w_fn3 == 3'b101) begin
                    w_dec_op = c_ALU_SRA;
                end else begin
                    w_dec_ill = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_zero_a  = 1'b1;
                w_sel_imm = 1'b1;
                w_dec_imm = w_imm_u;
            end
            default: w_dec_ill = 1'b1;
        endcase
    end

    // Only real, legal instructions that actually read a source can conflict with X.
    assign w_x_hit = x_we_i & (x_rd_i != 5'd0) & r_valid & ~w_dec_ill;
    assign w_haz1  = w_x_hit & w_use_rs1 & (x_rd_i == w_rs1_o);
    assign w_haz2  = w_x_hit & w_use_rs2 & (x_rd_i == w_rs2_o);

`ifdef STAGE_D_FWD_EN
    assign w_rs1_val   = w_haz1 ? x_dat_i : w_dat1_i;
    assign w_rs2_val   = w_haz2 ? x_dat_i : w_dat2_i;
    assign w_interlock = 1'b0;
`else
    logic w_unused_xdat;
    assign w_unused_xdat = ^x_dat_i;
    assign w_rs1_val     = w_dat1_i;
    assign w_rs2_val     = w_dat2_i;
    // A stall already holds the stage, so the interlock bubble only shows when X moves.
    assign w_interlock   = (w_haz1 | w_haz2) & ~x_stall_i;
`endif

    assign w_hold    = x_stall_i | w_interlock;
    assign d_ready_o = ~reset_i & ~w_hold;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ir    <= NOP_IR;
            r_valid <= 1'b0;
        end else if (!w_hold) begin
            if (f_ack_i) begin
                r_ir    <= f_dat_i;
                r_valid <= 1'b1;
            end else begin
                r_ir    <= NOP_IR;
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        d_valid_o   = r_valid & ~w_interlock;
        d_vs1_o     = '0;
        d_vs2_o     = '0;
        d_rd_o      = 5'd0;
        d_aluop_o   = c_ALU_ADD;
        d_illegal_o = 1'b0;
        if (r_valid && !w_interlock) begin
            if (w_dec_ill) begin
                d_illegal_o = 1'b1;
            end else begin
                d_vs1_o   = w_zero_a ? '0 : w_rs1_val;
                d_vs2_o   = w_sel_imm ? w_dec_imm : w_rs2_val;
                d_rd_o    = r_ir[11:7];
                d_aluop_o = w_dec_op;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_d_ex.sv
`default_nettype none
// tb_stage_d_ex : scoreboard bench for the decode stage; a 32-bit instance
// shadows the 64-bit one to cover the XLEN-dependent shift legality.
module tb_stage_d_ex;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, f_ack_i, x_stall_i, x_we_i;
    logic [31:0] f_dat_i;
    logic [4:0]  x_rd_i;
    logic [63:0] x_dat_i;

    logic        d_ready_o, d_valid_o, d_illegal_o;
    logic [4:0]  w_rs1_o, w_rs2_o, d_rd_o;
    logic [63:0] w_dat1_i, w_dat2_i, d_vs1_o, d_vs2_o;
    logic [3:0]  d_aluop_o;

    logic        unused_rdy32, unused_vld32, ill32;
    logic [4:0]  rs1_32, rs2_32, unused_rd32;
    logic [31:0] w_dat1_32, w_dat2_32, unused_vs1_32, unused_vs2_32;
    logic [63:0] rf1_32, rf2_32;
    logic [3:0]  unused_op32;

    // Register file stand-in: xN reads 0x1000+N, x0 reads zero.
    function automatic logic [63:0] rfv(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : 64'h1000 + 64'(a);
    endfunction

    assign w_dat1_i  = rfv(w_rs1_o);
    assign w_dat2_i  = rfv(w_rs2_o);
    assign rf1_32    = rfv(rs1_32);
    assign rf2_32    = rfv(rs2_32);
    assign w_dat1_32 = rf1_32[31:0];
    assign w_dat2_32 = rf2_32[31:0];

    stage_d_ex #(.XLEN(64)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i),
        .d_ready_o(d_ready_o), .x_stall_i(x_stall_i), .x_we_i(x_we_i),
        .x_rd_i(x_rd_i), .x_dat_i(x_dat_i), .w_rs1_o(w_rs1_o), .w_rs2_o(w_rs2_o),
        .w_dat1_i(w_dat1_i), .w_dat2_i(w_dat2_i), .d_valid_o(d_valid_o),
        .d_vs1_o(d_vs1_o), .d_vs2_o(d_vs2_o), .d_rd_o(d_rd_o),
        .d_aluop_o(d_aluop_o), .d_illegal_o(d_illegal_o)
    );

    stage_d_ex #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .reset_i(reset_i), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i),
        .d_ready_o(unused_rdy32), .x_stall_i(x_stall_i), .x_we_i(x_we_i),
        .x_rd_i(x_rd_i), .x_dat_i(x_dat_i[31:0]), .w_rs1_o(rs1_32), .w_rs2_o(rs2_32),
        .w_dat1_i(w_dat1_32), .w_dat2_i(w_dat2_32), .d_valid_o(unused_vld32),
        .d_vs1_o(unused_vs1_32), .d_vs2_o(unused_vs2_32), .d_rd_o(unused_rd32),
        .d_aluop_o(unused_op32), .d_illegal_o(ill32)
    );

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [63:0] vs1;
        logic [63:0] vs2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  op;
        logic        ill;
        logic        ill32;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t e_bub(input logic [4:0] rs1, input logic [4:0] rs2, input logic rdy);
        exp_t e;
        e = '{rdy: rdy, vld: 1'b0, vs1: 64'd0, vs2: 64'd0, rd: 5'd0, rs1: rs1, rs2: rs2,
              op: 4'd0, ill: 1'b0, ill32: 1'b0};
        return e;
    endfunction

    function automatic exp_t e_dec(input logic [63:0] vs1, input logic [63:0] vs2,
                                   input logic [4:0] rd, input logic [3:0] op,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic rdy);
        exp_t e;
        e = '{rdy: rdy, vld: 1'b1, vs1: vs1, vs2: vs2, rd: rd, rs1: rs1, rs2: rs2,
              op: op, ill: 1'b0, ill32: 1'b0};
        return e;
    endfunction

    function automatic exp_t e_ill(input logic [4:0] rs1, input logic [4:0] rs2, input logic rdy);
        exp_t e;
        e = '{rdy: rdy, vld: 1'b1, vs1: 64'd0, vs2: 64'd0, rd: 5'd0, rs1: rs1, rs2: rs2,
              op: 4'd0, ill: 1'b1, ill32: 1'b1};
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".ready"},  64'(d_ready_o),   64'(e.rdy));
        check({tag, ".valid"},  64'(d_valid_o),   64'(e.vld));
        check({tag, ".vs1"},    d_vs1_o,          e.vs1);
        check({tag, ".vs2"},    d_vs2_o,          e.vs2);
        check({tag, ".rd"},     64'(d_rd_o),      64'(e.rd));
        check({tag, ".aluop"},  64'(d_aluop_o),   64'(e.op));
        check({tag, ".illegal"},64'(d_illegal_o), 64'(e.ill));
        check({tag, ".rs1"},    64'(w_rs1_o),     64'(e.rs1));
        check({tag, ".rs2"},    64'(w_rs2_o),     64'(e.rs2));
        check({tag, ".ill32"},  64'(ill32),       64'(e.ill32));
    endtask

    // Drive one cycle of stimulus, queue what the outputs must show, then compare.
    task automatic step(input string tag, input logic rst, input logic ack,
                        input logic [31:0] dat, input logic stall, input logic we,
                        input logic [4:0] xrd, input exp_t e);
        @(negedge clk);
        reset_i   = rst;
        f_ack_i   = ack;
        f_dat_i   = dat;
        x_stall_i = stall;
        x_we_i    = we;
        x_rd_i    = xrd;
        q.push_back(e);
        #1;
        compare(tag, q.pop_front());
    endtask

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_t e_slli;

    initial begin
        reset_i = 1'b1; f_ack_i = 1'b1; f_dat_i = 32'hFFFF_FFFF;
        x_stall_i = 1'b0; x_we_i = 1'b0; x_rd_i = 5'd0; x_dat_i = 64'd1234;

        step("rst0", 1, 1, 32'hFFFF_FFFF, 0, 0, 0, e_bub(0, 0, 0));
        step("rst1", 1, 1, 32'hFFFF_FFFF, 0, 0, 0, e_bub(0, 0, 0));
        step("idle", 0, 1, 32'hFFF0_0293, 0, 0, 0, e_bub(0, 0, 1));
        step("addi", 0, 0, 32'h0000_0000, 0, 0, 0, e_dec(64'd0, c_ONES, 5, 0, 0, 31, 1));
        step("bub",  0, 1, 32'h4031_5093, 0, 0, 0, e_bub(0, 0, 1));
        step("stl1", 0, 1, 32'h0001_01B3, 1, 0, 0, e_dec(64'h1002, 64'd3, 1, 7, 2, 3, 0));
        step("stl2", 0, 1, 32'h0000_007F, 1, 0, 0, e_dec(64'h1002, 64'd3, 1, 7, 2, 3, 0));
        step("stl3", 0, 1, 32'h1234_5037, 1, 0, 0, e_dec(64'h1002, 64'd3, 1, 7, 2, 3, 0));
        step("rel",  0, 1, 32'h4020_8233, 0, 0, 0, e_dec(64'h1002, 64'd3, 1, 7, 2, 3, 1));
        step("sub",  0, 1, 32'h1234_53B7, 0, 1, 8, e_dec(64'h1001, 64'h1002, 4, 1, 1, 2, 1));
        step("lui",  0, 1, 32'h0001_01B3, 0, 1, 8, e_dec(64'd0, 64'h1234_5000, 7, 0, 8, 3, 1));
`ifdef STAGE_D_FWD_EN
        step("fwd",  0, 1, 32'h0000_007F, 0, 1, 2, e_dec(64'd1234, 64'd0, 3, 0, 2, 0, 1));
`else
        step("ilk",  0, 1, 32'h0000_007F, 0, 1, 2, e_bub(2, 0, 0));
        step("ilkr", 0, 1, 32'h0000_007F, 0, 0, 0, e_dec(64'h1002, 64'd0, 3, 0, 2, 0, 1));
`endif
        step("ill7f",0, 1, 32'h0220_8233, 0, 0, 0, e_ill(0, 0, 1));
        step("mul",  0, 1, 32'h0200_9093, 0, 0, 0, e_ill(1, 2, 1));
        e_slli = e_dec(64'h1001, 64'd32, 1, 2, 1, 0, 1);
        e_slli.ill32 = 1'b1;
        step("slli", 0, 1, 32'h8000_00B7, 0, 0, 0, e_slli);
        step("luin", 0, 1, 32'hFFFF_FFFF, 1, 0, 0,
             e_dec(64'd0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0, 0));
        step("rsth", 1, 1, 32'hFFFF_FFFF, 1, 0, 0,
             e_dec(64'd0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0, 0));
        step("post", 0, 0, 32'h0000_0000, 0, 0, 0, e_bub(0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
